somador_sequencial: RTL and testbench
=====================================

SOMADOR_SEQUENCIAL -- requirements
Module: somador_sequencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits added per clock cycle; legal configurations are WIDTH a multiple of DIGIT and DIGIT >= 1.
REQ-003 Port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: request a new operation, sampled on the rising edge.
REQ-006 Port sub, input, 1: mode select, 0 = a+b+cin, 1 = a-b; sampled with start.
REQ-007 Port a, input, WIDTH: first operand, sampled with start.
REQ-008 Port b, input, WIDTH: second operand, sampled with start.
REQ-009 Port cin, input, 1: carry-in for add mode, sampled with start, ignored when sub=1.
REQ-010 Port busy, output, 1: operation in progress.
REQ-011 Port done, output, 1: one-cycle pulse, result valid.
REQ-012 Port s, output, WIDTH: sum/difference.
REQ-013 Port cout, output, 1: unsigned carry-out; in sub mode 1 = no borrow (a >= b unsigned).
REQ-014 Port overflow, output, 1: two's-complement signed overflow of the result.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and FIN.
REQ-016 In IDLE or FIN, start=1 SHALL latch a, b XOR {WIDTH{sub}} and carry = (sub ? 1 : cin), clear the slice counter and go to CALC.
REQ-017 Each CALC cycle SHALL add the lowest DIGIT bits of both operand registers plus the carry register, shift the DIGIT-bit sum into the result register from the MSB side, store the slice carry-out and shift both operand registers right by DIGIT.
REQ-018 CALC SHALL last exactly N = WIDTH/DIGIT cycles, counted by a counter wide enough for N.
REQ-019 After the N-th slice the FSM SHALL enter FIN, with done=1 for exactly that one cycle, then return to IDLE unless start=1.
REQ-020 With start sampled at edge E, done SHALL be high in the cycle after edge E+N, so latency is N+1 cycles; back-to-back starts give one result every N+1 cycles.
REQ-021 s, cout and overflow SHALL update only on the edge that enters FIN and SHALL hold until the next FIN entry.
REQ-022 overflow SHALL be 1 iff the MSB of a equals the MSB of the effective b operand and differs from the MSB of s.
REQ-023 busy SHALL be 1 exactly while in CALC.
REQ-024 start while in CALC SHALL be ignored, with no effect on the operation in flight or on its result.
REQ-025 Input changes on a, b, sub and cin SHALL have no effect except on the edge that accepts start.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, s=0, cout=0 and overflow=0, and clear all internal registers, regardless of clock.
REQ-027 Reset asserted during CALC SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, DIGIT=4, add: a=0x3C, b=0x5A, cin=0 -> done at start+3 cycles, s=0x96, cout=0, overflow=1, busy high for 2 cycles.
REQ-029 Add: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, overflow=0; same operands with cin=1 -> s=0x01, cout=1.
REQ-030 Sub: a=0x10, b=0x20 -> s=0xF0, cout=0, overflow=0; then a=0x80, b=0x01 -> s=0x7F, cout=1, overflow=1.
REQ-031 start re-asserted with a=0x01, b=0x01 during CALC of 0x3C+0x5A -> result still 0x96; a start held high in the FIN cycle gives the next done 3 cycles later.
REQ-032 rst_n pulsed low mid-CALC -> outputs 0 asynchronously, no done pulse; the next start completes normally.
REQ-033 WIDTH=8, DIGIT=1 and WIDTH=16, DIGIT=8 -> random operands checked against a reference model, with done latency 9 and 3 cycles respectively.

Source files
------------

// File: rtl/somador_sequencial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, WIDTH/DIGIT slices.
// The result register fills from the MSB side, so it ends up aligned after N slices.
module somador_sequencial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]         sum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       res_nx;
  logic                   last;

  always_comb begin
    sum = {1'b0, a_q[DIGIT-1:0]}
        + {1'b0, b_q[DIGIT-1:0]}
        + {{DIGIT{1'b0}}, carry_q};
    cat    = {sum[DIGIT-1:0], res_q};
    res_nx = cat[WIDTH+DIGIT-1:DIGIT];
    last   = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1] ^ sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = res_nx;
        carry_d = sum[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // b is already inverted in sub mode, so one rule covers both
          s_d     = res_nx;
          cout_d  = sum[DIGIT];
          ovf_d   = (amsb_q == bmsb_q) && (res_nx[WIDTH-1] != amsb_q);
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == FIN);
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_somador_sequencial.sv
// Directed and randomized checks of somador_sequencial in three configurations.
module tb_somador_sequencial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] av = '0;
  logic [15:0] bv = '0;
  logic [2:0]  st = '0;

  logic        busy0, done0, cout0, ovf0;
  logic [7:0]  s0;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  s1;
  logic        busy2, done2, cout2, ovf2;
  logic [15:0] s2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  somador_sequencial #(.WIDTH(8), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub),
    .a(av[7:0]), .b(bv[7:0]), .cin(cin),
    .busy(busy0), .done(done0), .s(s0), .cout(cout0), .overflow(ovf0)
  );

  somador_sequencial #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub),
    .a(av[7:0]), .b(bv[7:0]), .cin(cin),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .overflow(ovf1)
  );

  somador_sequencial #(.WIDTH(16), .DIGIT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub),
    .a(av), .b(bv), .cin(cin),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .overflow(ovf2)
  );

  function automatic logic sel_done(input int w);
    case (w)
      1: return done1;
      2: return done2;
      default: return done0;
    endcase
  endfunction

  function automatic logic sel_busy(input int w);
    case (w)
      1: return busy1;
      2: return busy2;
      default: return busy0;
    endcase
  endfunction

  // lat = rising edges from the accepting edge (inclusive) until done is seen
  task automatic do_op(
    input  int          w,
    input  logic        sb,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output int          lat,
    output int          bcnt,
    output logic [15:0] so,
    output logic        co,
    output logic        ov
  );
    @(negedge clk);
    sub = sb; av = x; bv = y; cin = ci;
    st[w] = 1'b1;
    @(posedge clk); #1;
    st[w] = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!sel_done(w) && lat < 40) begin
      if (sel_busy(w)) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    case (w)
      1: begin so = {8'h00, s1}; co = cout1; ov = ovf1; end
      2: begin so = s2; co = cout2; ov = ovf2; end
      default: begin so = {8'h00, s0}; co = cout0; ov = ovf0; end
    endcase
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({busy0, done0, s0, cout0, ovf0} !== 12'h000)
      $display("FAIL reset_async: got %h expected 000",
               {busy0, done0, s0, cout0, ovf0});
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy0, done0, s0, cout0, ovf0} !== 12'h000)
      $display("FAIL reset_idle: got %h expected 000",
               {busy0, done0, s0, cout0, ovf0});
    else passed++;
  endtask

  task automatic test_add_basic();
    int lat, bc;
    logic [15:0] so;
    logic co, ov;
    do_op(0, 1'b0, 16'h3C, 16'h5A, 1'b0, lat, bc, so, co, ov);
    total++;
    if (lat !== 3) $display("FAIL add_lat: got %0d expected 3", lat);
    else passed++;
    total++;
    if (bc !== 2) $display("FAIL add_busy: got %0d expected 2", bc);
    else passed++;
    total++;
    if ({so[7:0], co, ov} !== {8'h96, 1'b0, 1'b1})
      $display("FAIL add_3c5a: got s=%h c=%b v=%b expected 96 0 1",
               so[7:0], co, ov);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({done0, s0} !== {1'b0, 8'h96})
      $display("FAIL done_pulse_hold: got done=%b s=%h expected 0 96",
               done0, s0);
    else passed++;
  endtask

  task automatic test_add_carry();
    int lat, bc;
    logic [15:0] so;
    logic co, ov;
    do_op(0, 1'b0, 16'hFF, 16'h01, 1'b0, lat, bc, so, co, ov);
    total++;
    if ({so[7:0], co, ov} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL add_ff01: got s=%h c=%b v=%b expected 00 1 0",
               so[7:0], co, ov);
    else passed++;
    do_op(0, 1'b0, 16'hFF, 16'h01, 1'b1, lat, bc, so, co, ov);
    total++;
    if ({so[7:0], co, ov} !== {8'h01, 1'b1, 1'b0})
      $display("FAIL add_ff01_cin: got s=%h c=%b v=%b expected 01 1 0",
               so[7:0], co, ov);
    else passed++;
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [15:0] so;
    logic co, ov;
    do_op(0, 1'b1, 16'h10, 16'h20, 1'b0, lat, bc, so, co, ov);
    total++;
    if ({so[7:0], co, ov} !== {8'hF0, 1'b0, 1'b0})
      $display("FAIL sub_1020: got s=%h c=%b v=%b expected f0 0 0",
               so[7:0], co, ov);
    else passed++;
    // cin must be ignored in sub mode
    do_op(0, 1'b1, 16'h80, 16'h01, 1'b1, lat, bc, so, co, ov);
    total++;
    if ({so[7:0], co, ov} !== {8'h7F, 1'b1, 1'b1})
      $display("FAIL sub_8001: got s=%h c=%b v=%b expected 7f 1 1",
               so[7:0], co, ov);
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; av = 16'h3C; bv = 16'h5A;
    st[0] = 1'b1;
    @(posedge clk); #1;
    av = 16'h01; bv = 16'h01;
    repeat (2) begin
      @(posedge clk); #1;
    end
    total++;
    if ({done0, s0} !== {1'b1, 8'h96})
      $display("FAIL start_in_calc: got done=%b s=%h expected 1 96",
               done0, s0);
    else passed++;
    @(posedge clk); #1;
    st[0] = 1'b0;
    total++;
    if ({busy0, done0} !== 2'b10)
      $display("FAIL fin_restart: got busy/done=%b expected 10",
               {busy0, done0});
    else passed++;
    repeat (2) begin
      @(posedge clk); #1;
    end
    total++;
    if ({done0, s0} !== {1'b1, 8'h02})
      $display("FAIL b2b_result: got done=%b s=%h expected 1 02",
               done0, s0);
    else passed++;
    av = 16'hAA; bv = 16'h55; sub = 1'b1; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy0, done0, s0} !== {2'b00, 8'h02})
      $display("FAIL input_noeffect: got %h expected 002",
               {busy0, done0, s0});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [15:0] so;
    logic co, ov;
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; av = 16'h3C; bv = 16'h5A;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy0, done0, s0, cout0, ovf0} !== 12'h000)
      $display("FAIL reset_mid: got %h expected 000",
               {busy0, done0, s0, cout0, ovf0});
    else passed++;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done0) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL reset_nodone: got %0d expected 0", seen);
    else passed++;
    do_op(0, 1'b0, 16'h3C, 16'h5A, 1'b0, lat, bc, so, co, ov);
    total++;
    if ({lat[3:0], so[7:0], co, ov} !== {4'd3, 8'h96, 1'b0, 1'b1})
      $display("FAIL after_reset: got lat=%0d s=%h c=%b v=%b expected 3 96 0 1",
               lat, so[7:0], co, ov);
    else passed++;
  endtask

  task automatic test_random();
    int lat, bc, wd;
    logic [15:0] so, x, y, ye;
    logic co, ov, sb, ci, ec, eo;
    logic [16:0] full;
    for (int w = 1; w <= 2; w++) begin
      wd = (w == 1) ? 8 : 16;
      for (int k = 0; k < 10; k++) begin
        x = 16'($urandom);
        y = 16'($urandom);
        sb = 1'($urandom);
        ci = 1'($urandom);
        if (wd == 8) begin
          x[15:8] = '0;
          y[15:8] = '0;
        end
        ye = sb ? ~y : y;
        if (wd == 8) ye[15:8] = '0;
        full = {1'b0, x} + {1'b0, ye} + {16'h0, (sb ? 1'b1 : ci)};
        if (wd == 8) begin
          ec = full[8];
          full[16:8] = '0;
          eo = (x[7] == ye[7]) && (full[7] != x[7]);
        end else begin
          ec = full[16];
          eo = (x[15] == ye[15]) && (full[15] != x[15]);
        end
        do_op(w, sb, x, y, ci, lat, bc, so, co, ov);
        total++;
        if (lat !== ((w == 1) ? 9 : 3))
          $display("FAIL rnd_lat w%0d: got %0d expected %0d",
                   w, lat, (w == 1) ? 9 : 3);
        else passed++;
        total++;
        if ({so, co, ov} !== {full[15:0], ec, eo})
          $display("FAIL rnd_res w%0d: got s=%h c=%b v=%b expected %h %b %b",
                   w, so, co, ov, full[15:0], ec, eo);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
